// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
// State encoding; 2'd3 is unused and falls back to IDLE.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_ha.sv
// Combinational full-adder bit slice built from two half adders.
module full_adder_ha (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder ha0 (
        .A (a),
        .B (b),
        .S (s0),
        .C (c0)
    );

    half_adder ha1 (
        .A (s0),
        .B (cin),
        .S (sum),
        .C (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two input bits.
module half_adder (
    input  logic A,
    input  logic B,
    output logic S,
    output logic C
);

    assign S = A ^ B;
    assign C = A & B;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice reused LSB first,
// carry held in a flop between cycles, WIDTH+1-bit result assembled in S.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   S
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               sum_bit;
    logic               cout;
    logic [WIDTH-1:0]   s_low;

    full_adder_ha u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (cout)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    accept   = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

    // Sum bits enter at the top of the low field and drift down to bit 0.
    always_comb begin
        s_low            = S[WIDTH-1:0] >> 1;
        s_low[WIDTH-1]   = sum_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
        end else if (state == RUN) begin
            a_sh         <= a_sh >> 1;
            b_sh         <= b_sh >> 1;
            carry        <= cout;
            cnt          <= cnt + CNT_W'(1);
            S[WIDTH-1:0] <= s_low;
            if (last) begin
                S[WIDTH] <= cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=4): directed adds,
// ignored restart, mid-run reset and a back-to-back exhaustive sweep.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   S;

    int tests;
    int fails;
    int cyc;

    logic [WIDTH:0] sb[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding add.
    always @(negedge clk) begin
        if (!rst && done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: got S=%0d, expected no done", S);
            end else begin
                logic [WIDTH:0] exp;
                exp = sb.pop_front();
                if (S !== exp) begin
                    fails++;
                    $display("FAIL sum: got %0d, expected %0d", S, exp);
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", int'(busy === 1'b0), 1);
    endtask

    // One add: start for one cycle, then count edges until done shows.
    task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input string name);
        int n;
        wait_idle();
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        sb.push_back((WIDTH+1)'(a) + (WIDTH+1)'(b));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A     = ~a;
        B     = ~b;
        check({name, "_busy"}, int'(busy), 1);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        // n counts the accept edge too: done after accept + WIDTH edges
        check({name, "_latency"}, n, WIDTH + 1);
        @(negedge clk);
    endtask

    initial begin
        int prev;
        bit got;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_S", int'(S), 0);

        run_add(4'd5, 4'd3, "add_5_3");
        run_add(4'hF, 4'hF, "add_f_f");
        check("carry_out_bit", int'(S[WIDTH]), 1);
        run_add(4'd0, 4'd0, "add_0_0");
        check("carry_cleared", int'(S), 0);
        run_add(4'd7, 4'd9, "add_7_9");

        // Restart request during RUN must be dropped.
        wait_idle();
        @(negedge clk);
        A     = 4'd2;
        B     = 4'd2;
        start = 1'b1;
        sb.push_back(5'd4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A     = 4'd1;
        B     = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("ignored_hold_S", int'(S), 4);
        check("ignored_idle", int'(busy), 0);

        // Reset on the second RUN edge discards the partial add.
        @(negedge clk);
        A     = 4'd9;
        B     = 4'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_S", int'(S), 0);
        repeat (8) @(negedge clk);
        check("midrst_no_done", int'(busy), 0);
        run_add(4'd9, 4'd6, "add_9_6");

        // Start held high: back-to-back adds over every operand pair.
        wait_idle();
        @(negedge clk);
        A     = 4'd0;
        B     = 4'd0;
        start = 1'b1;
        sb.push_back(5'd0);
        prev = 0;
        for (int i = 0; i < 256; i++) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (done === 1'b1) got = 1'b1;
            end
            check("sweep_done_seen", int'(got), 1);
            if (i > 0) check("sweep_period", cyc - prev, WIDTH + 2);
            prev = cyc;
            if (i < 255) begin
                logic [7:0] nx;
                nx = 8'(i + 1);
                A  = nx[7:4];
                B  = nx[3:0];
                sb.push_back(5'(nx[7:4]) + 5'(nx[3:0]));
            end else begin
                start = 1'b0;
            end
        end

        repeat (10) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
